// File: rtl/fir_tap_window_feeder.sv
// Serial sample stream to packed tap-window + coefficient bus feeder for the MAC.
// Delay line and double-buffered coefficient banks are built from per-slot cells.

module fir_tap_slot #(
  parameter int FXP_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 shift_en,
  input  logic [FXP_WIDTH-1:0] din,
  input  logic                 wr_en,
  input  logic [FXP_WIDTH-1:0] wr_data,
  input  logic                 copy,
  output logic [FXP_WIDTH-1:0] tap,
  output logic [FXP_WIDTH-1:0] coeff
);
  logic [FXP_WIDTH-1:0] shadow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tap    <= '0;
      shadow <= '0;
      coeff  <= '0;
    end else begin
      if (flush)         tap <= '0;
      else if (shift_en) tap <= din;
      if (wr_en) shadow <= wr_data;
      // A write landing on the copy edge is forwarded into the active bank.
      if (copy) coeff <= wr_en ? wr_data : shadow;
    end
  end
endmodule

module fir_tap_window_feeder #(
  parameter int FXP_WIDTH     = 16,
  parameter int FILTER_LENGTH = 32,
  parameter int TAP_BUS_WIDTH = FILTER_LENGTH*FXP_WIDTH,
  parameter int ADDR_W        = $clog2(FILTER_LENGTH)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic signed [FXP_WIDTH-1:0] s_sample,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic                        flush,
  input  logic                        coef_wr_en,
  input  logic [ADDR_W-1:0]           coef_wr_addr,
  input  logic signed [FXP_WIDTH-1:0] coef_wr_data,
  input  logic                        coef_commit,
  output logic                        commit_pending,
  output logic [TAP_BUS_WIDTH-1:0]    taps_out,
  output logic [TAP_BUS_WIDTH-1:0]    coeff_out,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic                        fill_done
);
  localparam logic [ADDR_W:0] FL_C = (ADDR_W+1)'(FILTER_LENGTH);

  logic [FILTER_LENGTH-1:0][FXP_WIDTH-1:0] taps, coeffs;
  logic [ADDR_W:0] cnt, cnt_inc, cnt_nxt;
  logic            safe, accept, full_next, copy;

  // Safe = no window is being held; both shifting and bank copy wait for it.
  assign safe      = !m_valid | m_ready;
  assign s_ready   = safe & !flush;
  assign accept    = s_valid & s_ready;
  assign cnt_inc   = cnt + 1'b1;
  assign full_next = (cnt_inc >= FL_C);
  assign copy      = (coef_commit | commit_pending) & safe;

  always_comb begin
    cnt_nxt = cnt;
    if (flush)                      cnt_nxt = '0;
    else if (accept && cnt != FL_C) cnt_nxt = cnt_inc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt            <= '0;
      fill_done      <= 1'b0;
      m_valid        <= 1'b0;
      commit_pending <= 1'b0;
    end else begin
      cnt       <= cnt_nxt;
      fill_done <= (cnt_nxt == FL_C);
      if (flush)                    m_valid <= 1'b0;
      else if (accept && full_next) m_valid <= 1'b1;
      else if (m_ready)             m_valid <= 1'b0;
      commit_pending <= copy ? 1'b0 : (commit_pending | coef_commit);
    end
  end

  for (genvar i = 0; i < FILTER_LENGTH; i++) begin : g_slot
    logic [FXP_WIDTH-1:0] din;
    if (i == 0) begin : g_head
      assign din = s_sample;
    end else begin : g_body
      assign din = taps[i-1];
    end

    fir_tap_slot #(.FXP_WIDTH(FXP_WIDTH)) u_slot (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (flush),
      .shift_en (accept),
      .din      (din),
      .wr_en    (coef_wr_en && (coef_wr_addr == ADDR_W'(i))),
      .wr_data  (coef_wr_data),
      .copy     (copy),
      .tap      (taps[i]),
      .coeff    (coeffs[i])
    );
  end

  assign taps_out  = taps;
  assign coeff_out = coeffs;
endmodule
